// File: rtl/sync_fifo_rd_ctrl.sv
// sync_fifo_rd_ctrl: read side of an 8-entry sync FIFO, 2-entry skid buffer.
// Define SYNC_FIFO_RD_CNT_EN to add the xfer_cnt pop counter output.
module sync_fifo_rd_ctrl #(
  parameter int DATA_W = 8
`ifdef SYNC_FIFO_RD_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occ
`ifdef SYNC_FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              inflight_q;
  logic              hd_q;
  logic              hd_d;
  logic              tl_q;
  logic              tl_d;
  logic [DATA_W-1:0] buf_q [2];
  logic              push;
  logic              pop;
  logic [2:0]        credit;

  assign pop    = m_valid & m_ready;
  assign push   = inflight_q & ~flush;
  // Slots committed after this cycle: held + landing - leaving.
  assign credit = {1'b0, occ_q}
                + {2'b00, inflight_q}
                - {2'b00, pop};

  // rst gates the issue so nothing is read while reset is held.
  assign fifo_rd_en = rst & ~fifo_empty & ~flush
                    & (credit < 3'd2);

  assign m_valid = (occ_q != S_EMPTY);
  assign m_data  = buf_q[hd_q];
  assign occ     = occ_q;

  // Occupancy FSM and head/tail pointers; flush overrides push/pop.
  always_comb begin
    occ_d = occ_q;
    hd_d  = hd_q;
    tl_d  = tl_q;
    if (flush) begin
      occ_d = S_EMPTY;
      hd_d  = 1'b0;
      tl_d  = 1'b0;
    end else begin
      if (push) tl_d = ~tl_q;
      if (pop)  hd_d = ~hd_q;
      unique case (occ_q)
        S_EMPTY: begin
          if (push) occ_d = S_ONE;
        end
        S_ONE: begin
          if (push & ~pop)      occ_d = S_TWO;
          else if (pop & ~push) occ_d = S_EMPTY;
        end
        S_TWO: begin
          if (pop) occ_d = S_ONE;
        end
        default: occ_d = S_EMPTY;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= S_EMPTY;
      hd_q       <= 1'b0;
      tl_q       <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      hd_q       <= hd_d;
      tl_q       <= tl_d;
      inflight_q <= fifo_rd_en;
    end
  end

  // Capture the landing FIFO word at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[tl_q] <= fifo_dout;
    end
  end

`ifdef SYNC_FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  assign xfer_cnt = cnt_q;

  // Count accepted stream words; survives flush, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// tb_sync_fifo_rd_ctrl: directed bench for sync_fifo_rd_ctrl.
// FIFO behaviour is modelled by mem/rp/wp with registered dout.
module tb_sync_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout = 8'h00;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occ;
`ifdef SYNC_FIFO_RD_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:63];
  logic [5:0] rp = 6'd0;
  logic [5:0] wp = 6'd0;
  int         rd_cnt = 0;
  logic       rd_q = 1'b0;
  logic       inv_bad = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_rd_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occ        (occ)
`ifdef SYNC_FIFO_RD_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 6'd1;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // A word landing while the buffer holds two would be a push in TWO.
  always @(posedge clk) begin
    if (rst && occ == 2'd2 && rd_q && !flush) inv_bad <= 1'b1;
    rd_q <= fifo_rd_en;
  end

  task automatic load(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 6'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    wp = rp;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    load(8'h11);
    load(8'h22);
    load(8'h33);
    repeat (2) @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en);
    end
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %0b want 0", m_valid);
    end
    n_chk++;
    if (occ !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_occ: got %0d want 0", occ);
    end
    n_chk++;
    if (m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 00", m_data);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_rd_en: got %0b want 1", fifo_rd_en);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_valid_n1: got %0b want 0", m_valid);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      n_fail++;
      $display("FAIL rel_first: got v=%0b d=%h want v=1 d=11",
               m_valid, m_data);
    end
    @(negedge clk);
    n_chk++;
    if (occ !== 2'd2 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_full: got occ=%0d rd=%0b want occ=2 rd=0",
               occ, fifo_rd_en);
    end
  endtask

  task automatic test_stream();
    int base;
    do_reset();
    base = rd_cnt;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(8'(i));
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_lat: got v=%0b want 0", m_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL stream_word%0d: got v=%0b d=%h want v=1 d=%h",
                 i, m_valid, m_data, 8'(i));
      end
      if (i == 7) begin
        n_chk++;
        if (fifo_rd_en !== 1'b0 || fifo_empty !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rd_stop: got rd=%0b want 0",
                   fifo_rd_en);
        end
      end
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0 || occ !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_end: got v=%0b occ=%0d want 0 0",
               m_valid, occ);
    end
    n_chk++;
    if (rd_cnt - base !== 8) begin
      n_fail++;
      $display("FAIL stream_reads: got %0d want 8", rd_cnt - base);
    end
  endtask

  task automatic test_back_pressure();
    int base;
    do_reset();
    base = rd_cnt;
    load(8'h21);
    load(8'h22);
    load(8'h23);
    repeat (3) @(negedge clk);
    n_chk++;
    if (rd_cnt - base !== 2 || occ !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_fill: got reads=%0d occ=%0d want 2 2",
               rd_cnt - base, occ);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== 8'h21) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%0b d=%h want v=1 d=21",
                 k, m_valid, m_data);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h22) begin
      n_fail++;
      $display("FAIL bp_w2: got v=%0b d=%h want v=1 d=22",
               m_valid, m_data);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h23) begin
      n_fail++;
      $display("FAIL bp_w3: got v=%0b d=%h want v=1 d=23",
               m_valid, m_data);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0 || rd_cnt - base !== 3) begin
      n_fail++;
      $display("FAIL bp_end: got v=%0b reads=%0d want 0 3",
               m_valid, rd_cnt - base);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    load(8'hA5);
    load(8'h5A);
    repeat (2) @(negedge clk);
    n_chk++;
    if (occ !== 2'd1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL pp_pre: got occ=%0d d=%h want 1 a5", occ, m_data);
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (occ !== 2'd1 || m_valid !== 1'b1 || m_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL pp_swap: got occ=%0d v=%0b d=%h want 1 1 5a",
               occ, m_valid, m_data);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_end: got v=%0b want 0", m_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    load(8'h31);
    load(8'h32);
    load(8'h33);
    repeat (2) @(negedge clk);
    n_chk++;
    if (occ !== 2'd1) begin
      n_fail++;
      $display("FAIL fl_pre: got occ=%0d want 1", occ);
    end
    flush = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_rd_en: got %0b want 0", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    n_chk++;
    if (occ !== 2'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_clear: got occ=%0d v=%0b want 0 0",
               occ, m_valid);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h33) begin
      n_fail++;
      $display("FAIL fl_next: got v=%0b d=%h want v=1 d=33",
               m_valid, m_data);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_end: got v=%0b want 0", m_valid);
    end
  endtask

  task automatic test_flush_idle();
    do_reset();
    flush = 1'b1;
    load(8'h41);
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fi_block: got rd=%0b want 0", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL fi_resume: got rd=%0b want 1", fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h41) begin
      n_fail++;
      $display("FAIL fi_word: got v=%0b d=%h want v=1 d=41",
               m_valid, m_data);
    end
  endtask

`ifdef SYNC_FIFO_RD_CNT_EN
  task automatic test_xfer_cnt();
    do_reset();
    n_chk++;
    if (xfer_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_rst: got %0d want 0", xfer_cnt);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) load(8'(8'h50 + i));
    repeat (14) @(negedge clk);
    n_chk++;
    if (xfer_cnt !== 16'd10 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_ten: got %0d v=%0b want 10 0",
               xfer_cnt, m_valid);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++;
    if (xfer_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL cnt_flush: got %0d want 10", xfer_cnt);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (xfer_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: got %0d want 0", xfer_cnt);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_push_pop();
    test_flush();
    test_flush_idle();
`ifdef SYNC_FIFO_RD_CNT_EN
    test_xfer_cnt();
`endif
    n_chk++;
    if (inv_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL push_in_two: got %0b want 0", inv_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
